// File: rtl/err_correction.sv
// err_correction: code-offset helper-data error corrector for the RO-PUF key path.
//
// The fresh response is XORed with the helper data (RplusC) to form a noisy
// codeword W. W is split into T interleaved lanes of L = N/T bits. Lane l,
// position k is W[k*T + l]. The lanes are decoded one per clock with a
// single-error-correcting code. The code uses a 6-bit position syndrome S and
// an overall parity P. The corrected word is XORed with the helper data again,
// which gives the enrollment response back.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      level request; sampled in IDLE/DONE
//   RplusC     helper data (enrollment response ^ codeword), N bits
//   response   fresh noisy PUF response, N bits
//   corrected  reconstructed response, valid while ready=1
//   ready      result valid (DONE state)
//   errors     bits corrected in the last run (saturating)
//   leds       bit l = lane l was uncorrectable in the last run

// Single-lane decoder. It is purely combinational.
module err_lane_dec #(
  parameter int L = 33
) (
  input  logic [L-1:0] lane,
  output logic [L-1:0] fixed,
  output logic         corr,
  output logic         unc
);
  logic [5:0] s;
  logic       p;

  always_comb begin
    s = '0;
    p = 1'b0;
    for (int k = 0; k < L; k++) begin
      if (lane[k]) s = s ^ 6'(k + 1);
      p = p ^ lane[k];
    end
  end

  always_comb begin
    fixed = lane;
    corr  = 1'b0;
    unc   = 1'b0;
    if (s == 6'd0 && !p) begin
      // clean lane
    end else if (p && s != 6'd0 && int'(s) <= L) begin
      fixed[int'(s) - 1] = ~lane[int'(s) - 1];
      corr = 1'b1;
    end else begin
      // An even number of errors, or a syndrome that points past the lane.
      unc = 1'b1;
    end
  end
endmodule

module err_correction #(
  parameter int N         = 264,
  parameter int T         = 8,
  parameter int BITS      = 8,
  parameter int DATA_BITS = 192
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    RplusC,
  input  logic [N-1:0]    response,
  output logic [N-1:0]    corrected,
  output logic            ready,
  output logic [BITS-1:0] errors,
  output logic [BITS-1:0] leds
);
  localparam int L  = N / T;
  localparam int CW = (T > 1) ? $clog2(T) : 1;

  if (N != T * L || L > 63 || BITS < T || DATA_BITS > N) begin : g_bad_param
    $error("err_correction: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    wreg, hreg, w_next;
  logic [CW-1:0]   cnt;
  logic            last_lane;
  logic            launch;

  logic [T-1:0][L-1:0] lanes;
  logic [L-1:0]        cur, fix;
  logic                corr, unc;

  // Gather the interleaved lanes out of the working word.
  for (genvar l = 0; l < T; l++) begin : g_lane
    for (genvar k = 0; k < L; k++) begin : g_pos
      assign lanes[l][k] = wreg[k*T + l];
    end
  end

  assign cur = lanes[cnt];

  err_lane_dec #(.L(L)) u_dec (
    .lane  (cur),
    .fixed (fix),
    .corr  (corr),
    .unc   (unc)
  );

  // Scatter the decoded lane back into its interleaved positions.
  always_comb begin
    w_next = wreg;
    for (int k = 0; k < L; k++) w_next[k*T + int'(cnt)] = fix[k];
  end

  assign last_lane = (cnt == CW'(T - 1));
  assign launch    = (state == IDLE || state == DONE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last_lane) state_nxt = DONE;
      DONE:    if (start) state_nxt = BUSY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wreg      <= '0;
      hreg      <= '0;
      cnt       <= '0;
      corrected <= '0;
      ready     <= 1'b0;
      errors    <= '0;
      leds      <= '0;
    end else if (launch) begin
      wreg   <= response ^ RplusC;
      hreg   <= RplusC;
      cnt    <= '0;
      ready  <= 1'b0;
      errors <= '0;
      leds   <= '0;
    end else if (state == BUSY) begin
      wreg <= w_next;
      cnt  <= last_lane ? '0 : cnt + 1'b1;
      if (corr && errors != {BITS{1'b1}}) errors <= errors + 1'b1;
      if (unc) leds[cnt] <= 1'b1;
      if (last_lane) begin
        corrected <= w_next ^ hreg;
        ready     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_err_correction.sv
module tb_err_correction;
  localparam int N = 264, T = 8, BITS = 8;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [N-1:0]    RplusC, response, corrected;
  logic            ready;
  logic [BITS-1:0] errors, leds;

  err_correction #(.N(N), .T(T), .BITS(BITS), .DATA_BITS(192)) dut (
    .clk(clk), .rst(rst), .start(start), .RplusC(RplusC), .response(response),
    .corrected(corrected), .ready(ready), .errors(errors), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [N-1:0]    rpc;
    logic [N-1:0]    flip;
    logic [N-1:0]    exp_corr;
    logic [BITS-1:0] exp_err;
    logic [BITS-1:0] exp_leds;
  } vec_t;

  typedef struct {
    logic [N-1:0]    corr;
    logic [BITS-1:0] err;
    logic [BITS-1:0] leds;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int checks = 0, fails = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Waits up to a bound for ready; returns the number of edges taken (-1 on timeout).
  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ready) begin cyc = i; break; end
    end
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({name, " queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({name, " corrected"}, corrected, e.corr);
    check({name, " errors"}, N'(errors), N'(e.err));
    check({name, " leds"}, N'(leds), N'(e.leds));
  endtask

  // Drive one run: start is held for 'hold' edges, then the result is checked.
  task automatic run_vec(input vec_t v, input int hold);
    exp_t e;
    int cyc;
    @(negedge clk);
    RplusC   = v.rpc;
    response = v.rpc ^ v.flip;
    start    = 1'b1;
    e.corr = v.exp_corr; e.err = v.exp_err; e.leds = v.exp_leds;
    exp_q.push_back(e);
    @(posedge clk); #1;                       // start edge E
    for (int i = 1; i < hold; i++) begin @(posedge clk); #1; end
    start = 1'b0;
    // hold-1 of the T decode edges have already elapsed
    wait_ready(cyc);
    if (cyc < 0) check({v.name, " ready timeout"}, 0, 1);
    else check({v.name, " latency"}, N'(cyc + hold - 1), N'(T));
    pop_compare(v.name);
  endtask

  logic [N-1:0] rc, one, b;
  int c1, c2;

  initial begin
    rc  = 264'h1212a6fdda38ded8101c5322eeb778b013231679f5fceb86c751c0ce8b21e13cd1;
    one = {{(N-1){1'b0}}, 1'b1};

    vecs[0] = '{"zero_err", rc, '0, rc, 8'd0, 8'h00};
    vecs[1] = '{"single_bit0", rc, one, rc, 8'd1, 8'h00};
    vecs[2] = '{"eight_err", rc, N'(264'hFF), rc, 8'd8, 8'h00};
    vecs[3] = '{"unc_lane0", rc, N'(264'h101), rc ^ N'(264'h101), 8'd0, 8'h01};
    b = one << 263;                              // lane 7, j = 33 = L
    vecs[4] = '{"top_bit_lane7", rc, b, rc, 8'd1, 8'h00};
    b = (one << 250) | (one << 122) | (one << 2); // lane 2, j=32,16,1: S=49 > L, P=1
    vecs[5] = '{"s_over_L", rc, b, rc ^ b, 8'd0, 8'h04};
    b = (one << 5) | (one << 13) | (one << 21);   // lane 5, j=1,2,3: S=0, P=1
    vecs[6] = '{"s0_p1", rc, b, rc ^ b, 8'd0, 8'h20};
    b = one | (one << 1) | (one << 9);            // lane 0 fixable, lane 1 j=1,2
    vecs[7] = '{"mixed", ~rc, b, (~rc) ^ (one << 1) ^ (one << 9), 8'd1, 8'h02};

    rst = 1'b1; start = 1'b0; RplusC = '0; response = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", N'(ready), 0);
    check("reset corrected", corrected, 0);
    check("reset errors", N'(errors), 0);
    check("reset leds", N'(leds), 0);
    @(negedge clk); rst = 1'b0;

    run_vec(vecs[0], 2);
    for (int i = 1; i < 8; i++) run_vec(vecs[i], 1);

    // Hold start through DONE: ready is high for one cycle, then a new run starts.
    @(negedge clk);
    RplusC = rc; response = rc ^ N'(264'hFF); start = 1'b1;
    exp_q.push_back('{rc, 8'd8, 8'h00});
    exp_q.push_back('{rc, 8'd8, 8'h00});
    @(posedge clk); #1;
    wait_ready(c1);
    check("b2b first latency", N'(c1), N'(T));
    pop_compare("b2b first");
    @(posedge clk); #1;
    check("b2b ready pulse", N'(ready), 0);
    wait_ready(c2);
    check("b2b period", N'(c2 + 1), N'(T + 1));
    pop_compare("b2b second");
    @(negedge clk); start = 1'b0;

    // A reset during BUSY aborts the run and leaves no result.
    @(negedge clk);
    RplusC = rc; response = rc ^ one; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort ready", N'(ready), 0);
    check("abort corrected", corrected, 0);
    check("abort errors", N'(errors), 0);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort stays idle", N'(ready), 0);
    check("abort no result", corrected, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, fails);
    $finish;
  end
endmodule
